uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Receive-side frame sequencer for the 8-bit UART. Oversamples the serial rx line, detects
//  start bit, shifts in data LSB-first, checks optional even/odd parity and the stop bit.
//  Presents the assembled byte with parity/framing status as a one-cycle valid pulse.
//  Sits between the rx pin synchroniser/baud generator and the RX FIFO/host interface.
// PARAMETERS
//  OVERSAMPLE  16  baud_tick pulses per bit period; even, >= 4
//  DATA_BITS   8   data bits per frame; 5..8; data_out upper bits zero when < 8
// PORTS
//  clk            in   1  system clock, all logic rising-edge
//  rst_n          in   1  asynchronous active-low reset
//  baud_tick      in   1  one-cycle enable at OVERSAMPLE x baud rate
//  rx             in   1  raw serial input, idle high (asynchronous to clk)
//  parity_en      in   1  1 = frame carries a parity bit after data
//  parity_type    in   1  0 = even, 1 = odd
//  data_out       out  8  last received byte, LSB = first bit on line
//  data_valid     out  1  one-cycle pulse: data_out/status updated
//  parity_error   out  1  parity mismatch for byte in data_out
//  framing_error  out  1  stop bit sampled low for byte in data_out
//  busy           out  1  high whenever state != IDLE
// BEHAVIOUR
//  - rx passes through 2-flop synchroniser (reset value 1); all decisions use synced rx_s.
//  - Reset: state=IDLE, data_out=0, data_valid=0, parity_error=0, framing_error=0, busy=0,
//    tick and bit counters 0. Reset asserted mid-frame aborts frame; no valid pulse emitted.
//  - Counters advance only on baud_tick; no baud_tick => FSM frozen (except reset).
//  - States: IDLE, START, DATA, PARITY, STOP, BREAK.
//  - IDLE: on baud_tick with rx_s=0 -> START, tick_cnt=0; parity_en/parity_type latched
//    here; changes during the frame are ignored until next IDLE->START.
//  - START: at tick_cnt=OVERSAMPLE/2-1 sample rx_s: 0 -> DATA (tick_cnt=0, bit_cnt=0);
//    1 -> false start, back to IDLE, no outputs change.
//  - DATA: sample at tick_cnt=OVERSAMPLE-1 (mid-bit), shift into shift reg LSB-first,
//    running parity ^= bit; after DATA_BITS samples -> PARITY if latched parity_en else STOP.
//  - PARITY: sample at OVERSAMPLE-1; error = (bit ^ data_xor) != latched parity_type
//    (even: data^p must be 0; odd: must be 1). -> STOP.
//  - STOP: sample at OVERSAMPLE-1. Next clk: data_out<=shift reg, data_valid=1 for exactly
//    one cycle, parity_error<=computed (0 if parity disabled), framing_error<=(stop==0).
//    stop=1 -> IDLE immediately (back-to-back frames accepted, re-arm at half stop bit).
//    stop=0 -> BREAK.
//  - BREAK: wait for rx_s=1 on a baud_tick, then IDLE. Prevents line-low break from
//    triggering continuous false frames.
//  - data_out, parity_error, framing_error hold until next data_valid; byte is delivered
//    even when errors flagged (consumer decides).
//  - Latency: data_valid asserts 1 clk after the stop-bit sample tick.
//  - tick_cnt width clog2(OVERSAMPLE); bit_cnt width 3; wraps are impossible by design.
// TESTING
//  T1 OVERSAMPLE=16, tick every clk, parity off, send 0xA5 8N1 -> one data_valid pulse,
//     data_out=0xA5, parity_error=0, framing_error=0; busy low after.
//  T2 parity_en=1, type=0, send 0xAA with parity bit 0 -> data_out=0xAA, parity_error=0;
//     repeat 0xF8 with parity bit 0 -> parity_error=1, data_out=0xF8.
//  T3 parity_en=1, type=1, send 0xCC with parity 1 -> parity_error=0; 0xF0 parity 0 ->
//     parity_error=1.
//  T4 rx low for 5 ticks then high -> false start, no data_valid, state back to IDLE.
//  T5 send 0x3C with stop=0, hold rx low 40 ticks, then high, then 0x81 valid frame ->
//     first pulse framing_error=1 data_out=0x3C; exactly one pulse during low; second
//     pulse 0x81 with framing_error=0.
//  T6 assert rst_n=0 during DATA of 0x55 -> outputs 0, busy=0 immediately; after release
//     next valid frame 0x12 received correctly; toggle parity_type mid-frame -> ignored.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampled UART receive frame sequencer.
// Synchronises rx, walks start/data/parity/stop and reports the byte with error flags.
module uart_rx_frame_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Received parity bit disagrees with the data XOR for the selected sense.
  function automatic logic parity_mismatch(input logic data_xor, input logic pbit,
                                           input logic odd);
    return (data_xor ^ pbit) != odd;
  endfunction

  logic                 r_rx_meta, r_rx_sync;
  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_tick_cnt, w_tick_nxt;
  logic [2:0]           r_bit_cnt, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par_acc, w_par_acc_nxt;
  logic                 r_par_err, w_par_err_nxt;
  logic                 r_par_en, w_par_en_nxt;
  logic                 r_par_type, w_par_type_nxt;
  logic                 w_deliver;
  logic [7:0]           w_data_ext;
  logic [7:0]           r_data_out;
  logic                 r_data_valid, r_parity_error, r_framing_error, r_busy;

  // Two-flop synchroniser for the asynchronous rx pin, idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Next-state and datapath decisions; everything is frozen between baud ticks.
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = r_tick_cnt;
    w_bit_nxt      = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_par_acc_nxt  = r_par_acc;
    w_par_err_nxt  = r_par_err;
    w_par_en_nxt   = r_par_en;
    w_par_type_nxt = r_par_type;
    w_deliver      = 1'b0;
    if (baud_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_sync) begin
            w_state_nxt    = ST_START;
            w_tick_nxt     = '0;
            w_par_en_nxt   = parity_en;
            w_par_type_nxt = parity_type;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_START: begin
          if (r_tick_cnt == HALF_LAST) begin
            w_tick_nxt    = '0;
            w_bit_nxt     = 3'd0;
            w_par_acc_nxt = 1'b0;
            w_par_err_nxt = 1'b0;
            if (!r_rx_sync) begin
              w_state_nxt = ST_DATA;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        ST_DATA: begin
          if (r_tick_cnt == FULL_LAST) begin
            w_tick_nxt    = '0;
            w_shift_nxt   = {r_rx_sync, r_shift[DATA_BITS-1:1]};
            w_par_acc_nxt = r_par_acc ^ r_rx_sync;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 3'd1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        ST_PARITY: begin
          if (r_tick_cnt == FULL_LAST) begin
            w_tick_nxt    = '0;
            w_par_err_nxt = parity_mismatch(r_par_acc, r_rx_sync, r_par_type);
            w_state_nxt   = ST_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        ST_STOP: begin
          if (r_tick_cnt == FULL_LAST) begin
            w_tick_nxt  = '0;
            w_deliver   = 1'b1;
            // Re-arming at mid stop bit lets a back-to-back start edge be caught.
            w_state_nxt = r_rx_sync ? ST_IDLE : ST_BREAK;
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        ST_BREAK: begin
          if (r_rx_sync) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_BREAK;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = '0;
          w_bit_nxt   = 3'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Zero-extend the shift register to the fixed 8-bit output width.
  always_comb begin
    w_data_ext                = 8'd0;
    w_data_ext[DATA_BITS-1:0] = r_shift;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, shift register and latched frame configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_par_err  <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_par_acc  <= w_par_acc_nxt;
      r_par_err  <= w_par_err_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_type <= w_par_type_nxt;
    end
  end

  // Registered outputs; byte and status hold until the next delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out      <= 8'd0;
      r_data_valid    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_data_valid <= w_deliver;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (w_deliver) begin
        r_data_out      <= w_data_ext;
        r_parity_error  <= r_par_en & r_par_err;
        r_framing_error <= ~r_rx_sync;
      end else begin
        r_data_out      <= r_data_out;
        r_parity_error  <= r_parity_error;
        r_framing_error <= r_framing_error;
      end
    end
  end

  assign data_out      = r_data_out;
  assign data_valid    = r_data_valid;
  assign parity_error  = r_parity_error;
  assign framing_error = r_framing_error;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: serial frames built from bit lists, expected
// byte/status pushed to a queue and popped by an independent output monitor.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, parity_error, framing_error, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   gate_ticks = 1'b0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_tick     (baud_tick),
    .rx            (rx),
    .parity_en     (parity_en),
    .parity_type   (parity_type),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Output monitor: every valid pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        check("valid_one_cycle", int'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: data_out %0h with no frame pending", data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_out", int'(data_out), int'(mon_e.data));
          check("parity_error", int'(parity_error), int'(mon_e.pe));
          check("framing_error", int'(framing_error), int'(mon_e.fe));
        end
      end
      prev_valid = data_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Hold rx at a level for n baud ticks; ticks optionally gated randomly.
  task automatic hold_ticks(input logic val, input int n);
    int cnt = 0;
    while (cnt < n) begin
      @(negedge clk);
      rx = val;
      baud_tick = gate_ticks ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (baud_tick) cnt++;
    end
  endtask

  // Send one frame; the expectation comes straight from the frame contents.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input logic pbit, input logic stop, input bit toggle);
    exp_t e;
    parity_en   = pen;
    parity_type = ptype;
    e.data = d;
    e.pe   = pen && ((($countones(d) + int'(pbit)) % 2) != int'(ptype));
    e.fe   = !stop;
    exp_q.push_back(e);
    hold_ticks(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (toggle && i == 4) parity_type = ~parity_type;
      hold_ticks(d[i], 16);
    end
    if (pen) hold_ticks(pbit, 16);
    hold_ticks(stop, 16);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rpen, rptype, rpbit, rstop;
    int         wait_cnt;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", int'(data_out), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_parity_error", int'(parity_error), 0);
    check("rst_framing_error", int'(framing_error), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    hold_ticks(1'b1, 8);

    // T1: 0xA5 8N1
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_delivered", exp_q.size(), 0);
    hold_ticks(1'b1, 4);
    check("t1_busy_after", int'(busy), 0);

    // T2: even parity, good then bad
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // T3: odd parity, good then bad
    send_frame(8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    hold_ticks(1'b1, 8);
    check("t23_delivered", exp_q.size(), 0);

    // T4: glitch shorter than half a bit is a false start
    parity_en = 1'b0;
    hold_ticks(1'b0, 5);
    #1 check("t4_busy_during", int'(busy), 1);
    hold_ticks(1'b1, 20);
    check("t4_busy_after", int'(busy), 0);

    // T5: framing error followed by line break, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_ticks(1'b0, 40);
    check("t5_one_pulse", exp_q.size(), 0);
    check("t5_busy_in_break", int'(busy), 1);
    hold_ticks(1'b1, 20);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    hold_ticks(1'b1, 8);
    check("t5_delivered", exp_q.size(), 0);

    // T6: reset in the middle of the data bits of 0x55
    hold_ticks(1'b0, 16);
    hold_ticks(1'b1, 16);
    hold_ticks(1'b0, 16);
    hold_ticks(1'b1, 8);
    check("t6_busy_before_rst", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data_out", int'(data_out), 0);
    check("t6_rst_valid", int'(data_valid), 0);
    check("t6_rst_framing", int'(framing_error), 0);
    check("t6_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold_ticks(1'b1, 20);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    hold_ticks(1'b1, 8);
    check("t6_delivered", exp_q.size(), 0);

    // Randomised frames, some with gated baud ticks and framing errors
    for (int n = 0; n < 30; n++) begin
      gate_ticks = ($urandom_range(0, 1) == 1);
      rd     = 8'($urandom_range(0, 255));
      rpen   = 1'($urandom_range(0, 1));
      rptype = 1'($urandom_range(0, 1));
      rpbit  = 1'($urandom_range(0, 1));
      rstop  = ($urandom_range(0, 4) != 0);
      send_frame(rd, rpen, rptype, rpbit, rstop, 1'b0);
      if (!rstop) begin
        hold_ticks(1'b0, $urandom_range(0, 20));
        hold_ticks(1'b1, $urandom_range(4, 8));
      end else begin
        hold_ticks(1'b1, $urandom_range(0, 6));
      end
    end
    gate_ticks = 1'b0;
    hold_ticks(1'b1, 16);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
